// File: rtl/err_stats_pkg.sv
// rtl/err_stats_pkg.sv - shared types and width helpers for the adder error-statistics stage
// Contents: run state enum, operand width, accumulator width functions.
package err_stats_pkg;

    // Width of the adder results being compared: {Cout, S[8:0]}
    localparam int DATA_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // N samples of at most 1023 each fit in DATA_W + log2(N) bits
    function automatic int sum_w(input int samples_log2);
        return DATA_W + samples_log2;
    endfunction

    // Counts 0..N inclusive
    function automatic int cnt_w(input int samples_log2);
        return samples_log2 + 1;
    endfunction

endpackage

// File: rtl/abs_diff10.sv
// rtl/abs_diff10.sv - unsigned absolute difference and inequality flag of two 10-bit values
// Ports: a, b (10-bit operands) -> d = |a - b|, neq = (a != b). Purely combinational.
module abs_diff10
    import err_stats_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] d,
    output logic              neq
);

    // Subtract the smaller from the larger so the result never wraps
    always_comb begin
        d   = '0;
        neq = (a != b);
        if (a >= b) begin
            d = a - b;
        end else begin
            d = b - a;
        end
    end

endmodule

// File: rtl/err_stats_9b.sv
// rtl/err_stats_9b.sv - error statistics between exact and approximate 9-bit adder results over 2**SAMPLES_LOG2 samples
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begins a run from IDLE or DONE
//   in_valid / in_ready sample handshake; in_ready is high only in RUN
//   s_exact, s_approx   10-bit adder results {Cout, S[8:0]}
//   busy, done          run in progress / results valid and held
//   err_count           samples where the two results differ
//   sum_abs_err         sum of absolute errors
//   max_abs_err         largest absolute error
//   mean_abs_err        sum_abs_err >> SAMPLES_LOG2
module err_stats_9b
    import err_stats_pkg::*;
#(
    parameter int SAMPLES_LOG2 = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_W-1:0]                s_exact,
    input  logic [DATA_W-1:0]                s_approx,
    output logic                             busy,
    output logic                             done,
    output logic [cnt_w(SAMPLES_LOG2)-1:0]   err_count,
    output logic [sum_w(SAMPLES_LOG2)-1:0]   sum_abs_err,
    output logic [DATA_W-1:0]                max_abs_err,
    output logic [DATA_W-1:0]                mean_abs_err
);

    localparam int SW = sum_w(SAMPLES_LOG2);
    localparam int CW = cnt_w(SAMPLES_LOG2);

    state_t state, state_nxt;

    // Sample index within the run; all-ones marks the final sample
    logic [SAMPLES_LOG2-1:0] cnt;

    logic [DATA_W-1:0] diff;
    logic              diff_neq;

    // Stage-1 registers
    logic [DATA_W-1:0] abs_err1;
    logic              neq1;
    logic              v1;

    logic accept;
    logic run_start;
    logic last_sample;

    abs_diff10 u_abs_diff (
        .a   (s_exact),
        .b   (s_approx),
        .d   (diff),
        .neq (diff_neq)
    );

    assign accept      = in_valid && (state == RUN);
    assign last_sample = &cnt;

    always_comb begin
        state_nxt = state;
        run_start = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    run_start = 1'b1;
                end
            end
            RUN: begin
                if (accept && last_sample) begin
                    state_nxt = DRAIN;
                end
            end
            // The last stage-1 result is accumulated on the edge leaving DRAIN
            DRAIN: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    run_start = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter holds at N-1 after the final accept; only a new run clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (run_start) begin
            cnt <= '0;
        end else if (accept && !last_sample) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abs_err1 <= '0;
            neq1     <= 1'b0;
            v1       <= 1'b0;
        end else if (run_start) begin
            abs_err1 <= '0;
            neq1     <= 1'b0;
            v1       <= 1'b0;
        end else begin
            v1 <= accept;
            if (accept) begin
                abs_err1 <= diff;
                neq1     <= diff_neq;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count   <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
        end else if (run_start) begin
            err_count   <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
        end else if (v1) begin
            err_count   <= err_count + CW'(neq1);
            sum_abs_err <= sum_abs_err + SW'(abs_err1);
            if (abs_err1 > max_abs_err) begin
                max_abs_err <= abs_err1;
            end
        end
    end

    // Upper DATA_W bits of the sum are exactly the truncated mean
    assign mean_abs_err = sum_abs_err[SW-1:SAMPLES_LOG2];

    assign in_ready = (state == RUN);
    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_err_stats_9b.sv
// tb/tb_err_stats_9b.sv - directed table-driven bench for err_stats_9b (N=4 and N=256 instances)
module tb_err_stats_9b;

    logic clk;
    logic rst_n;

    // N = 4 instance
    logic        start, in_valid, in_ready, busy, done;
    logic [9:0]  s_exact, s_approx;
    logic [2:0]  err_count;
    logic [11:0] sum_abs_err;
    logic [9:0]  max_abs_err, mean_abs_err;

    // N = 256 instance
    logic        start8, in_valid8, in_ready8, busy8, done8;
    logic [9:0]  s_exact8, s_approx8;
    logic [8:0]  err_count8;
    logic [17:0] sum_abs_err8;
    logic [9:0]  max_abs_err8, mean_abs_err8;

    int n_cmp = 0;
    int n_bad = 0;

    err_stats_9b #(.SAMPLES_LOG2(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .s_exact      (s_exact),
        .s_approx     (s_approx),
        .busy         (busy),
        .done         (done),
        .err_count    (err_count),
        .sum_abs_err  (sum_abs_err),
        .max_abs_err  (max_abs_err),
        .mean_abs_err (mean_abs_err)
    );

    err_stats_9b #(.SAMPLES_LOG2(8)) dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start8),
        .in_valid     (in_valid8),
        .in_ready     (in_ready8),
        .s_exact      (s_exact8),
        .s_approx     (s_approx8),
        .busy         (busy8),
        .done         (done8),
        .err_count    (err_count8),
        .sum_abs_err  (sum_abs_err8),
        .max_abs_err  (max_abs_err8),
        .mean_abs_err (mean_abs_err8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][9:0] ex;
        logic [3:0][9:0] ap;
        int err;
        int sum;
        int mx;
        int mean;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input int e0, a0, e1, a1, e2, a2, e3, a3,
                           input int err, sum, mx, mean);
        vec_t v;
        v.ex[0] = 10'(e0); v.ap[0] = 10'(a0);
        v.ex[1] = 10'(e1); v.ap[1] = 10'(a1);
        v.ex[2] = 10'(e2); v.ap[2] = 10'(a2);
        v.ex[3] = 10'(e3); v.ap[3] = 10'(a3);
        v.err = err; v.sum = sum; v.mx = mx; v.mean = mean;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".err_count"}, 32'(err_count), 0);
        chk({tag, ".sum"}, 32'(sum_abs_err), 0);
        chk({tag, ".max"}, 32'(max_abs_err), 0);
        chk({tag, ".mean"}, 32'(mean_abs_err), 0);
        chk({tag, ".done"}, 32'(done), 0);
    endtask

    // Start a run, stream four back-to-back pairs, check drain timing and results
    task automatic run_vec(input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ".ready_after_start"}, 32'(in_ready), 1);
        chk({tag, ".busy_after_start"}, 32'(busy), 1);
        chk_all_zero({tag, ".cleared"});
        for (int j = 0; j < 4; j++) begin
            in_valid = 1'b1;
            s_exact  = vecs[idx].ex[j];
            s_approx = vecs[idx].ap[j];
            tick();
        end
        in_valid = 1'b0;
        chk({tag, ".ready_drain"}, 32'(in_ready), 0);
        chk({tag, ".busy_drain"}, 32'(busy), 1);
        chk({tag, ".done_early"}, 32'(done), 0);
        tick();
        chk({tag, ".done"}, 32'(done), 1);
        chk({tag, ".busy_done"}, 32'(busy), 0);
        chk({tag, ".err_count"}, 32'(err_count), 32'(vecs[idx].err));
        chk({tag, ".sum"}, 32'(sum_abs_err), 32'(vecs[idx].sum));
        chk({tag, ".max"}, 32'(max_abs_err), 32'(vecs[idx].mx));
        chk({tag, ".mean"}, 32'(mean_abs_err), 32'(vecs[idx].mean));
    endtask

    initial begin
        bit [0:6] gap_pat;
        int       acc_i;
        int       waited;

        //            pair0      pair1      pair2       pair3      err  sum   max   mean
        add_vec(677, 677, 677, 677, 677, 677,  677, 677,   0,    0,    0,    0);
        add_vec(100,  96,  50,  53, 1022,  0,    7,   7,   3, 1029, 1022,  257);
        add_vec(  0,1023,   0,1023,    0,1023,   0,1023,   4, 4092, 1023, 1023);
        add_vec(512, 511,   0,   1, 1023,1022, 300, 300,   3,    3,    1,    0);
        add_vec( 10,  20,  20,  10,    5,   0,   0,   5,   4,   30,   10,    7);

        // Reset held with start and in_valid asserted
        rst_n = 1'b0;
        start = 1'b1; in_valid = 1'b1; s_exact = 10'd0; s_approx = 10'd1023;
        start8 = 1'b0; in_valid8 = 1'b0; s_exact8 = 10'd0; s_approx8 = 10'd0;
        tick(); tick(); tick();
        chk_all_zero("reset");
        chk("reset.in_ready", 32'(in_ready), 0);
        chk("reset.busy", 32'(busy), 0);
        start = 1'b0;
        rst_n = 1'b1;
        // in_valid with a maximal-error pair while IDLE must be ignored
        tick(); tick(); tick();
        chk_all_zero("idle");
        chk("idle.in_ready", 32'(in_ready), 0);
        chk("idle.busy", 32'(busy), 0);
        in_valid = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(i);
        end

        // Gaps, with a start pulse mid-run that must be ignored
        gap_pat = 7'b1001011;
        acc_i   = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 7; j++) begin
            in_valid = gap_pat[j];
            start    = (j == 2);
            if (gap_pat[j]) begin
                // abs errors 1,2,3,4 alternating sign
                s_exact  = (acc_i % 2 == 0) ? 10'(acc_i + 1) : 10'd0;
                s_approx = (acc_i % 2 == 0) ? 10'd0 : 10'(acc_i + 1);
                acc_i++;
            end else begin
                s_exact  = 10'd0;
                s_approx = 10'd1023;
            end
            tick();
        end
        start = 1'b0;
        in_valid = 1'b0;
        chk("gap.ready_drain", 32'(in_ready), 0);
        chk("gap.done_early", 32'(done), 0);
        tick();
        chk("gap.done", 32'(done), 1);
        chk("gap.sum", 32'(sum_abs_err), 10);
        chk("gap.err_count", 32'(err_count), 4);
        chk("gap.max", 32'(max_abs_err), 4);
        chk("gap.mean", 32'(mean_abs_err), 2);

        // in_valid in DONE is ignored and results stay put
        in_valid = 1'b1; s_exact = 10'd0; s_approx = 10'd1023;
        tick(); tick(); tick();
        in_valid = 1'b0;
        chk("done_hold.done", 32'(done), 1);
        chk("done_hold.sum", 32'(sum_abs_err), 10);
        chk("done_hold.err_count", 32'(err_count), 4);
        chk("done_hold.max", 32'(max_abs_err), 4);

        // Abort mid-run with asynchronous reset
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; s_exact = 10'd0; s_approx = 10'd1023;
        tick(); tick();
        in_valid = 1'b0;
        chk("abort.partial_sum", 32'(sum_abs_err), 1023);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        chk("abort.busy", 32'(busy), 0);
        chk("abort.in_ready", 32'(in_ready), 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_vec(1);

        // Start from DONE clears everything on its edge
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all_zero("restart");
        chk("restart.busy", 32'(busy), 1);

        // Full-width run on the N = 256 instance
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        in_valid8 = 1'b1; s_exact8 = 10'd1023; s_approx8 = 10'd0;
        for (int j = 0; j < 256; j++) begin
            tick();
        end
        in_valid8 = 1'b0;
        chk("wide.ready_drain", 32'(in_ready8), 0);
        waited = 0;
        while (!done8 && waited < 10) begin
            tick();
            waited++;
        end
        chk("wide.done_latency", 32'(waited), 1);
        chk("wide.sum", 32'(sum_abs_err8), 261888);
        chk("wide.max", 32'(max_abs_err8), 1023);
        chk("wide.err_count", 32'(err_count8), 256);
        chk("wide.mean", 32'(mean_abs_err8), 1023);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
